// File: rtl/fetch_ifid_stage_if.sv
// Signal bundle between the fetch/IF-ID stage, instruction memory and the hazard detector.
// master = fetch stage, slave = memory, hazard detector and ID stage.
interface fetch_ifid_stage_if;
    logic [15:0] imem_data;
    logic        PC_Hold;
    logic        IF_ID_Hold;
    logic        Delay;
    logic        branch;
    logic [15:0] branch_target;
    logic        ExcepSig;
    logic [15:0] imem_addr;
    logic [15:0] IF_ID_Instr;
    logic [15:0] IF_ID_PC;
    logic        IF_ID_Valid;
    logic [3:0]  IF_ID_Op1;
    logic [3:0]  IF_ID_Op2;
    logic [3:0]  Opcode;
    logic [3:0]  FunctionCode;
    logic        exc_taken;

    modport master (
        input  imem_data, PC_Hold, IF_ID_Hold, Delay, branch, branch_target, ExcepSig,
        output imem_addr, IF_ID_Instr, IF_ID_PC, IF_ID_Valid, IF_ID_Op1, IF_ID_Op2,
               Opcode, FunctionCode, exc_taken
    );

    modport slave (
        output imem_data, PC_Hold, IF_ID_Hold, Delay, branch, branch_target, ExcepSig,
        input  imem_addr, IF_ID_Instr, IF_ID_PC, IF_ID_Valid, IF_ID_Op1, IF_ID_Op2,
               Opcode, FunctionCode, exc_taken
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Fetch stage: owns the PC and the IF/ID register, applies hazard holds, bubbles,
// branch flushes and exception redirects, and slices the latched instruction into fields.
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] EXC_VECTOR   = 16'h0F00,
    parameter logic [15:0] NOP_INSTR    = 16'hF000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    fetch_ifid_stage_if.master  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_EXC   = 2'd2
    } state_t;

    // Counter preload counts the bubbles still owed after the branch edge itself.
    localparam logic [2:0] FLUSH_INIT   = 3'(FLUSH_CYCLES - 1);
    localparam state_t     BRANCH_STATE = (FLUSH_CYCLES > 32'd1) ? ST_FLUSH : ST_RUN;

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] instr_r;
    logic [15:0] ifid_pc_r;
    logic        valid_r;
    logic [2:0]  cnt_r;
    logic        exc_r;
    logic [15:0] pc_inc_s;

    assign pc_inc_s = pc_r + 16'd2;

    // PC, IF/ID register and control FSM, evaluated in redirect/hazard priority order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_RUN;
            pc_r      <= RESET_PC;
            instr_r   <= NOP_INSTR;
            ifid_pc_r <= 16'h0000;
            valid_r   <= 1'b0;
            cnt_r     <= 3'd0;
            exc_r     <= 1'b0;
        end else begin
            exc_r <= 1'b0;
            if (bus.ExcepSig && (state_r != ST_EXC)) begin
                pc_r    <= EXC_VECTOR;
                instr_r <= NOP_INSTR;
                valid_r <= 1'b0;
                cnt_r   <= 3'd0;
                exc_r   <= 1'b1;
                state_r <= ST_EXC;
            end else if (bus.branch) begin
                pc_r    <= bus.branch_target;
                instr_r <= NOP_INSTR;
                valid_r <= 1'b0;
                cnt_r   <= FLUSH_INIT;
                state_r <= BRANCH_STATE;
            end else if ((state_r == ST_FLUSH) && (cnt_r != 3'd0)) begin
                pc_r    <= bus.PC_Hold ? pc_r : pc_inc_s;
                instr_r <= NOP_INSTR;
                valid_r <= 1'b0;
                cnt_r   <= cnt_r - 3'd1;
                state_r <= (cnt_r == 3'd1) ? ST_RUN : ST_FLUSH;
            end else if (bus.Delay) begin
                instr_r <= NOP_INSTR;
                valid_r <= 1'b0;
                state_r <= ST_RUN;
            end else begin
                pc_r <= bus.PC_Hold ? pc_r : pc_inc_s;
                // Holding IF/ID while the PC advances drops one instruction; tolerated here.
                if (!bus.IF_ID_Hold) begin
                    instr_r   <= bus.imem_data;
                    ifid_pc_r <= pc_inc_s;
                    valid_r   <= 1'b1;
                end else begin
                    instr_r   <= instr_r;
                    ifid_pc_r <= ifid_pc_r;
                    valid_r   <= valid_r;
                end
                state_r <= ST_RUN;
            end
        end
    end

    assign bus.imem_addr    = pc_r;
    assign bus.IF_ID_Instr  = instr_r;
    assign bus.IF_ID_PC     = ifid_pc_r;
    assign bus.IF_ID_Valid  = valid_r;
    assign bus.exc_taken    = exc_r;
    assign bus.Opcode       = instr_r[15:12];
    assign bus.IF_ID_Op1    = instr_r[11:8];
    assign bus.IF_ID_Op2    = instr_r[7:4];
    assign bus.FunctionCode = instr_r[3:0];

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage (FLUSH_CYCLES=3, memory echoes its address).
module tb_fetch_ifid_stage;

    logic clk;
    logic reset_n;
    fetch_ifid_stage_if bus ();

    fetch_ifid_stage #(
        .RESET_PC     (16'h0000),
        .EXC_VECTOR   (16'h0F00),
        .NOP_INSTR    (16'hF000),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.imem_data = bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk_ifpc;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] ifpc;
        logic        valid;
        logic        exc;
    } exp_t;

    typedef struct {
        logic        ph;
        logic        ih;
        logic        dl;
        logic        br;
        logic [15:0] tgt;
        logic        ex;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic ph, input logic ih, input logic dl, input logic br,
                       input logic [15:0] tgt, input logic ex, input logic [15:0] pc,
                       input logic [15:0] instr, input logic [15:0] ifpc,
                       input logic valid, input logic exc);
        vec_t v;
        v.ph = ph; v.ih = ih; v.dl = dl; v.br = br; v.tgt = tgt; v.ex = ex;
        v.e.chk_ifpc = valid;
        v.e.pc = pc; v.e.instr = instr; v.e.ifpc = ifpc; v.e.valid = valid; v.e.exc = exc;
        vecs.push_back(v);
    endtask

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        logic [15:0] fields;
        fields = {bus.Opcode, bus.IF_ID_Op1, bus.IF_ID_Op2, bus.FunctionCode};
        cmp16({tag, ".pc"}, bus.imem_addr, e.pc);
        cmp16({tag, ".instr"}, bus.IF_ID_Instr, e.instr);
        cmp16({tag, ".valid"}, {15'd0, bus.IF_ID_Valid}, {15'd0, e.valid});
        cmp16({tag, ".exc"}, {15'd0, bus.exc_taken}, {15'd0, e.exc});
        cmp16({tag, ".fields"}, fields, e.instr);
        if (e.chk_ifpc) begin
            cmp16({tag, ".ifpc"}, bus.IF_ID_PC, e.ifpc);
        end else begin
            checks = checks;
        end
    endtask

    task automatic clear_inputs();
        bus.PC_Hold = 1'b0; bus.IF_ID_Hold = 1'b0; bus.Delay = 1'b0;
        bus.branch = 1'b0; bus.branch_target = 16'h0000; bus.ExcepSig = 1'b0;
    endtask

    initial begin
        exp_t e;
        exp_t got;
        // Sequence from reset: normal fetch, holds, delay, flushes, exceptions, wrap.
        add(0,0,0,0,16'h0000,0, 16'h0002,16'h0000,16'h0002,1,0);
        add(0,0,0,0,16'h0000,0, 16'h0004,16'h0002,16'h0004,1,0);
        add(1,1,0,0,16'h0000,0, 16'h0004,16'h0002,16'h0004,1,0);
        add(1,1,0,0,16'h0000,0, 16'h0004,16'h0002,16'h0004,1,0);
        add(0,0,0,0,16'h0000,0, 16'h0006,16'h0004,16'h0006,1,0);
        add(0,0,1,0,16'h0000,0, 16'h0006,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0008,16'h0006,16'h0008,1,0);
        add(0,0,0,1,16'h0040,0, 16'h0040,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0042,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0044,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0046,16'h0044,16'h0046,1,0);
        add(0,0,0,1,16'h0080,0, 16'h0080,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0082,16'hF000,16'h0000,0,0);
        add(0,0,0,1,16'h0100,0, 16'h0100,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0102,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0104,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0106,16'h0104,16'h0106,1,0);
        add(0,0,1,1,16'h0200,0, 16'h0200,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0202,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0204,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'h0206,16'h0204,16'h0206,1,0);
        add(1,0,0,1,16'h0300,1, 16'h0F00,16'hF000,16'h0000,0,1);
        add(0,0,0,0,16'h0000,1, 16'h0F02,16'h0F00,16'h0F02,1,0);
        add(0,0,0,0,16'h0000,1, 16'h0F00,16'hF000,16'h0000,0,1);
        add(0,0,0,0,16'h0000,0, 16'h0F02,16'h0F00,16'h0F02,1,0);
        add(1,0,0,0,16'h0000,0, 16'h0F02,16'h0F02,16'h0F04,1,0);
        add(0,1,0,0,16'h0000,0, 16'h0F04,16'h0F02,16'h0F04,1,0);
        add(0,0,0,0,16'h0000,0, 16'h0F06,16'h0F04,16'h0F06,1,0);
        add(0,0,0,1,16'hFFF8,0, 16'hFFF8,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'hFFFA,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'hFFFC,16'hF000,16'h0000,0,0);
        add(0,0,0,0,16'h0000,0, 16'hFFFE,16'hFFFC,16'hFFFE,1,0);
        add(0,0,0,0,16'h0000,0, 16'h0000,16'hFFFE,16'h0000,1,0);
        add(0,0,0,1,16'h0040,0, 16'h0040,16'hF000,16'h0000,0,0);

        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = '{chk_ifpc:1'b1, pc:16'h0000, instr:16'hF000, ifpc:16'h0000, valid:1'b0, exc:1'b0};
        check_out("reset", e);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.PC_Hold       = vecs[i].ph;
            bus.IF_ID_Hold    = vecs[i].ih;
            bus.Delay         = vecs[i].dl;
            bus.branch        = vecs[i].br;
            bus.branch_target = vecs[i].tgt;
            bus.ExcepSig      = vecs[i].ex;
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check_out($sformatf("vec%0d", i), got);
        end
        clear_inputs();

        // Mid-FLUSH asynchronous reset: outputs must clear before the next edge.
        #2;
        reset_n = 1'b0;
        #1;
        e = '{chk_ifpc:1'b1, pc:16'h0000, instr:16'hF000, ifpc:16'h0000, valid:1'b0, exc:1'b0};
        check_out("async_rst", e);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        e = '{chk_ifpc:1'b1, pc:16'h0002, instr:16'h0000, ifpc:16'h0002, valid:1'b1, exc:1'b0};
        check_out("post_rst", e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
